vram_word_fetcher: RTL and testbench

Burst-read front end for one 32-bit read-only VRAM port (port 1, 2 or 3) of the VRAM arbiter. It takes a descriptor (start word address and word count), issues back-to-back word reads under the arbiter's strobe/ack protocol, and tolerates arbitrary stall cycles caused by higher-priority ports. Returned words are buffered in a small FIFO and handed to a downstream renderer (layer or sprite) over a valid/ready stream.

---
 rtl/vram_pkg.sv | 15 +
 rtl/word_fifo.sv | 65 ++++++
 rtl/vram_word_fetcher.sv | 143 ++++++++++++++
 tb/tb_vram_word_fetcher.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared VRAM port definitions: word geometry and the burst fetch state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vram_pkg;

    localparam int VRAM_WORD_ADDR_W = 15;
    localparam int VRAM_WORD_W      = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/word_fifo.sv
// First-word-fall-through FIFO with occupancy count and synchronous flush.
// Latency: a pushed word is visible at head_dat the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; flush beats both.
module word_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_rdy,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_en;
    logic          pop_en;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign push_en  = push_vld && !full && !flush;
    assign pop_en   = pop_rdy && !empty && !flush;
    // Head is forced to zero when empty so stale words never leak downstream.
    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vram_word_fetcher.sv
// Burst reader for one read-only VRAM arbiter port, feeding a valid/ready word stream.
// Latency: first strobe the cycle after start; word at out_data the cycle after its ack.
// Backpressure: strobe withheld unless the FIFO has a slot for every outstanding ack.
module vram_word_fetcher
    import vram_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [VRAM_WORD_ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]            word_count,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    output logic [VRAM_WORD_ADDR_W-1:0] bus_addr,
    output logic                        bus_strobe,
    input  logic                        bus_ack,
    input  logic [VRAM_WORD_W-1:0]      bus_rddata,
    output logic [VRAM_WORD_W-1:0]      out_data,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t                state;
    fetch_state_t                state_nxt;
    logic                        done_nxt;
    logic [VRAM_WORD_ADDR_W-1:0] base;
    logic [LEN_W-1:0]            len;
    logic [LEN_W-1:0]            acked;
    logic [LEN_W:0]              acked_inc;
    logic                        ack_vld;
    logic                        abort_vld;
    logic                        start_ld;
    logic                        fifo_push;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [CW-1:0]               fifo_count;
    logic                        fifo_room_ok;
    logic                        last_pop;

    // Acks only mean something while fetching; anything else is a stale grant.
    assign ack_vld   = bus_ack && (state == FETCH);
    assign abort_vld = abort && (state != IDLE);
    assign start_ld  = (state == IDLE) && start && !abort && (word_count != '0);
    assign fifo_push = ack_vld && !abort_vld;

    // The ack cycle already advances address and room so the same word is not re-granted.
    assign acked_inc    = {1'b0, acked} + {{LEN_W{1'b0}}, ack_vld};
    assign fifo_room_ok = ({1'b0, fifo_count} + {{CW{1'b0}}, ack_vld} + (CW+1)'(1))
                          <= (CW+1)'(DEPTH);

    assign bus_addr   = base + VRAM_WORD_ADDR_W'(acked_inc);
    assign bus_strobe = (state == FETCH) && !abort && (acked_inc < {1'b0, len}) && fifo_room_ok;

    assign busy      = (state != IDLE);
    assign out_valid = !fifo_empty;
    assign last_pop  = out_ready && (fifo_count == CW'(1)) && !fifo_push;

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (word_count == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = FETCH;
                    end
                end
            end
            FETCH: begin
                if (abort) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (acked == len) begin
                    // Last word may already be popped in the cycle its count lands.
                    if (last_pop) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort || last_pop) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base  <= '0;
            len   <= '0;
            acked <= '0;
        end else if (start_ld) begin
            base  <= start_addr;
            len   <= word_count;
            acked <= '0;
        end else if (fifo_push) begin
            acked <= acked + LEN_W'(1);
        end
    end

    word_fifo #(
        .DEPTH (DEPTH),
        .W     (VRAM_WORD_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (abort_vld),
        .push_vld (fifo_push),
        .push_dat (bus_rddata),
        .pop_rdy  (out_ready),
        .head_dat (out_data),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

endmodule

// File: tb/tb_vram_word_fetcher.sv
// Directed bench for vram_word_fetcher with a behavioural arbiter port model.
// Latency/backpressure: model grants at the clock edge and acks the following cycle.
module tb_vram_word_fetcher;
    import vram_pkg::*;

    localparam int DEPTH = 4;
    localparam int LEN_W = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [14:0] start_addr;
    logic [7:0]  word_count;
    logic        abort;
    logic        busy;
    logic        done;
    logic [14:0] bus_addr;
    logic        bus_strobe;
    logic        bus_ack;
    logic [31:0] bus_rddata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          strobe_cnt = 0;
    int          last_pop_cyc = -1;
    bit          stall_mode = 1'b0;
    bit          hold_chk   = 1'b0;
    bit          stray_ack  = 1'b0;
    logic [14:0] grant_q [$];
    int          grant_cyc [$];
    logic [31:0] pop_q [$];

    vram_word_fetcher #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .word_count (word_count),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .bus_addr   (bus_addr),
        .bus_strobe (bus_strobe),
        .bus_ack    (bus_ack),
        .bus_rddata (bus_rddata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] wdat(input logic [14:0] a);
        return 32'hC0DE_0000 | {17'd0, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        grant_q.delete();
        grant_cyc.delete();
        pop_q.delete();
    endtask

    task automatic start_burst(input logic [14:0] a, input logic [7:0] n, output int s);
        tick();
        start      = 1'b1;
        start_addr = a;
        word_count = n;
        s          = cyc;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            sample();
            n++;
        end
        check(tag, 32'(done_cnt != d0), 32'd1);
    endtask

    // Grant addresses and popped data must both follow base, base+1, ... with 15-bit wrap.
    task automatic check_seq(input string tag, input logic [14:0] b, input int n);
        logic [14:0] a;
        for (int i = 0; i < n; i++) begin
            a = b + 15'(i);
            check({tag, " addr"}, 32'(grant_q[i]), 32'(a));
            check({tag, " data"}, pop_q[i], wdat(a));
        end
    endtask

    // Arbiter port model plus passive monitors, all sampled mid-cycle.
    initial begin : bus_model
        int          stall_left;
        bit          gnt;
        bit          stray;
        bit          prev_strobe;
        bit          prev_gnt;
        logic [14:0] gaddr;
        logic [14:0] prev_addr;
        bus_ack = 1'b0;
        bus_rddata = '0;
        stall_left = 0;
        prev_strobe = 1'b0;
        prev_gnt = 1'b0;
        prev_addr = '0;
        gaddr = '0;
        forever begin
            @(negedge clk);
            #0;
            if (!stall_mode) stall_left = 0;
            if (hold_chk && prev_strobe && !prev_gnt) begin
                check("stall hold strobe", 32'(bus_strobe), 32'd1);
                check("stall hold addr", 32'(bus_addr), 32'(prev_addr));
            end
            check("fifo push when full", 32'(dut.fifo_push && dut.fifo_full), 32'd0);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus_strobe) strobe_cnt++;
            if (out_valid && out_ready) begin
                pop_q.push_back(out_data);
                last_pop_cyc = cyc;
            end
            gnt = 1'b0;
            if (bus_strobe) begin
                if (stall_left == 0) begin
                    gnt   = 1'b1;
                    gaddr = bus_addr;
                    grant_q.push_back(bus_addr);
                    grant_cyc.push_back(cyc);
                    stall_left = stall_mode ? int'($urandom_range(0, 5)) : 0;
                end else begin
                    stall_left--;
                end
            end
            prev_strobe = bus_strobe;
            prev_gnt    = gnt;
            prev_addr   = bus_addr;
            stray       = stray_ack;
            @(posedge clk);
            #1;
            bus_ack    = gnt | stray;
            bus_rddata = gnt ? wdat(gaddr) : (stray ? 32'hDEAD_BEEF : 32'h0);
        end
    end

    initial begin : stimulus
        int s;
        int sc;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        start_addr = '0;
        word_count = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst bus_addr", 32'(bus_addr), 32'd0);
        check("rst bus_strobe", 32'(bus_strobe), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", out_data, 32'd0);
        rst_n = 1'b1;
        tick();

        // Uncontested 4-word burst, consumer always ready.
        clear_logs();
        out_ready = 1'b1;
        start_burst(15'h0100, 8'd4, s);
        wait_done("t1 done", 100);
        check("t1 grants", 32'(grant_q.size()), 32'd4);
        check("t1 pops", 32'(pop_q.size()), 32'd4);
        check_seq("t1", 15'h0100, 4);
        check("t1 first grant cyc", 32'(grant_cyc[0]), 32'(s + 1));
        check("t1 last grant cyc", 32'(grant_cyc[3]), 32'(s + 4));
        check("t1 last pop cyc", 32'(last_pop_cyc), 32'(s + 6));
        check("t1 done cyc", 32'(done_cyc), 32'(last_pop_cyc + 1));
        check("t1 busy after", 32'(busy), 32'd0);

        // Address wrap at the top of the word space.
        clear_logs();
        start_burst(15'h7FFE, 8'd4, s);
        wait_done("t2 done", 100);
        check("t2 grants", 32'(grant_q.size()), 32'd4);
        check_seq("t2", 15'h7FFE, 4);

        // Consumer stalled: fetch must stop once the FIFO is committed full.
        clear_logs();
        out_ready = 1'b0;
        start_burst(15'h0200, 8'd6, s);
        repeat (12) tick();
        check("t3 grants held", 32'(grant_q.size()), 32'd4);
        check("t3 strobe low", 32'(bus_strobe), 32'd0);
        check("t3 out_valid", 32'(out_valid), 32'd1);
        check("t3 head", out_data, wdat(15'h0200));
        check("t3 busy", 32'(busy), 32'd1);
        out_ready = 1'b1;
        wait_done("t3 done", 100);
        check("t3 grants", 32'(grant_q.size()), 32'd6);
        check("t3 pops", 32'(pop_q.size()), 32'd6);
        check_seq("t3", 15'h0200, 6);

        // Random arbiter stalls.
        clear_logs();
        stall_mode = 1'b1;
        hold_chk   = 1'b1;
        start_burst(15'h1234, 8'd16, s);
        wait_done("t4 done", 1000);
        hold_chk   = 1'b0;
        stall_mode = 1'b0;
        check("t4 grants", 32'(grant_q.size()), 32'd16);
        check("t4 pops", 32'(pop_q.size()), 32'd16);
        check_seq("t4", 15'h1234, 16);

        // Abort with an ack in flight, plus a stray late ack after abort.
        tick();
        clear_logs();
        out_ready = 1'b0;
        start_burst(15'h0300, 8'd8, s);
        tick();
        tick();
        abort     = 1'b1;
        stray_ack = 1'b1;
        sample();
        check("t5 strobe in abort", 32'(bus_strobe), 32'd0);
        check("t5 busy in abort", 32'(busy), 32'd1);
        tick();
        abort     = 1'b0;
        stray_ack = 1'b0;
        sample();
        check("t5 done", 32'(done), 32'd1);
        check("t5 busy", 32'(busy), 32'd0);
        check("t5 out_valid", 32'(out_valid), 32'd0);
        tick();
        sample();
        check("t5 late ack dropped", 32'(out_valid), 32'd0);
        check("t5 done once", 32'(done), 32'd0);
        check("t5 grants", 32'(grant_q.size()), 32'd2);
        clear_logs();
        out_ready = 1'b1;
        start_burst(15'h0400, 8'd2, s);
        wait_done("t5 restart done", 100);
        check("t5 restart grants", 32'(grant_q.size()), 32'd2);
        check_seq("t5 restart", 15'h0400, 2);

        // Zero-length descriptor.
        clear_logs();
        sc = strobe_cnt;
        start_burst(15'h0600, 8'd0, s);
        sample();
        check("t6 done", 32'(done), 32'd1);
        check("t6 done cyc", 32'(done_cyc), 32'(s + 1));
        check("t6 busy", 32'(busy), 32'd0);
        tick();
        tick();
        check("t6 no strobe", 32'(strobe_cnt), 32'(sc));

        // start together with abort in IDLE: abort wins, start ignored.
        tick();
        start      = 1'b1;
        abort      = 1'b1;
        start_addr = 15'h0700;
        word_count = 8'd3;
        tick();
        start = 1'b0;
        abort = 1'b0;
        sample();
        check("t7 busy", 32'(busy), 32'd0);
        check("t7 done", 32'(done), 32'd0);
        check("t7 strobe", 32'(bus_strobe), 32'd0);

        // Asynchronous reset mid-burst.
        out_ready = 1'b0;
        start_burst(15'h0500, 8'd8, s);
        tick();
        tick();
        check("t8 busy before", 32'(busy), 32'd1);
        check("t8 out_valid before", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t8 busy", 32'(busy), 32'd0);
        check("t8 done", 32'(done), 32'd0);
        check("t8 bus_addr", 32'(bus_addr), 32'd0);
        check("t8 bus_strobe", 32'(bus_strobe), 32'd0);
        check("t8 out_valid", 32'(out_valid), 32'd0);
        check("t8 out_data", out_data, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("t8 idle out_valid", 32'(out_valid), 32'd0);
        check("t8 idle busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
